bf_exec_unit: RTL and testbench

Brainfuck instruction execution unit sitting directly upstream of the tape module. Fetches 4-bit opcodes from a combinational-read program memory, decodes them and drives the tape's command strobes (set, move, roll back, delete). Resolves loop brackets by scanning program memory with a depth counter. Handles console input/output through valid/ready handshakes.

---
 rtl/bf_exec_unit.sv | 211 +++++++++++++++++++++
 tb/tb_bf_exec_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_exec_unit.sv
// Brainfuck fetch/decode/execute unit driving the tape's command strobes, with bracket scanning and console handshakes.
// Optional single-step dispatch gating is compiled in with `define BF_EXEC_STEP_EN.
module bf_exec_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned DEPTH_WIDTH = 6
) (
  input  logic                working_clock,
  input  logic                reset,
  input  logic                start,
`ifdef BF_EXEC_STEP_EN
  input  logic                step_mode,
  input  logic                step,
`endif
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [3:0]          prog_data,
  input  logic                tape_ready,
  input  logic [3:0]          tape_symbol,
  output logic [3:0]          tape_new_symbol,
  output logic                tape_set_symbol,
  output logic                tape_move,
  output logic                tape_move_dir,
  output logic                roll_back,
  output logic                tape_delete,
  input  logic                in_valid,
  input  logic [3:0]          in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [3:0]          out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic                halted,
  output logic                error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_IN_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT_WAIT = 3'd3;
  localparam logic [2:0] S_SCAN_FWD = 3'd4;
  localparam logic [2:0] S_SCAN_BWD = 3'd5;
  localparam logic [2:0] S_HALT     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  localparam logic [3:0] OP_HAT = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MOL = 4'd3;
  localparam logic [3:0] OP_MOR = 4'd4;
  localparam logic [3:0] OP_INP = 4'd5;
  localparam logic [3:0] OP_OUP = 4'd6;
  localparam logic [3:0] OP_LOL = 4'd7;
  localparam logic [3:0] OP_LOR = 4'd8;
  localparam logic [3:0] OP_CEO = 4'd9;
  localparam logic [3:0] OP_ZER = 4'd10;

  localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);

  logic [2:0]             state, state_next;
  logic [PC_WIDTH-1:0]    pc, pc_next;
  logic [DEPTH_WIDTH-1:0] depth, depth_next;
  logic [3:0]             out_data_next;
  logic                   dispatch;
  logic                   pc_last, pc_first, depth_full;
  logic                   adv, fwd, bwd;

`ifdef BF_EXEC_STEP_EN
  assign dispatch = tape_ready && (!step_mode || step);
`else
  assign dispatch = tape_ready;
`endif

  assign pc_last    = (pc == '1);
  assign pc_first   = (pc == '0);
  assign depth_full = (depth == '1);

  assign prog_addr   = pc;
  assign busy        = (state == S_EXEC) || (state == S_IN_WAIT) || (state == S_OUT_WAIT) ||
                       (state == S_SCAN_FWD) || (state == S_SCAN_BWD);
  assign halted      = (state == S_HALT);
  assign error       = (state == S_ERROR);
  assign in_ready    = (state == S_IN_WAIT);
  assign out_valid   = (state == S_OUT_WAIT);
  assign tape_delete = 1'b0;

  always_comb begin
    tape_set_symbol = 1'b0;
    tape_new_symbol = '0;
    tape_move       = 1'b0;
    tape_move_dir   = 1'b0;
    roll_back       = 1'b0;
    if (state == S_EXEC && dispatch) begin
      case (prog_data)
        OP_ADD: begin tape_set_symbol = 1'b1; tape_new_symbol = tape_symbol + 4'd1; end
        OP_SUB: begin tape_set_symbol = 1'b1; tape_new_symbol = tape_symbol - 4'd1; end
        OP_MOL: tape_move = 1'b1;
        OP_MOR: begin tape_move = 1'b1; tape_move_dir = 1'b1; end
        OP_CEO: roll_back = 1'b1;
        OP_ZER: tape_set_symbol = 1'b1;
        default: ;
      endcase
    end else if (state == S_IN_WAIT && in_valid) begin
      tape_set_symbol = 1'b1;
      tape_new_symbol = in_data;
    end
  end

  // adv/fwd/bwd collect the pc stepping shared by several states; bounds checks live in one place below.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    depth_next    = depth;
    out_data_next = out_data;
    adv           = 1'b0;
    fwd           = 1'b0;
    bwd           = 1'b0;
    case (state)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          state_next = S_EXEC;
          pc_next    = '0;
          depth_next = '0;
        end
      end
      S_EXEC: begin
        if (dispatch) begin
          case (prog_data)
            OP_HAT: state_next = S_HALT;
            OP_INP: state_next = S_IN_WAIT;
            OP_OUP: begin
              out_data_next = tape_symbol;
              state_next    = S_OUT_WAIT;
            end
            OP_LOL: begin
              if (tape_symbol == '0) begin
                depth_next = DEPTH_ONE;
                state_next = S_SCAN_FWD;
                fwd        = 1'b1;
              end else adv = 1'b1;
            end
            OP_LOR: begin
              if (tape_symbol != '0) begin
                depth_next = DEPTH_ONE;
                state_next = S_SCAN_BWD;
                bwd        = 1'b1;
              end else adv = 1'b1;
            end
            default: adv = 1'b1;
          endcase
        end
      end
      S_IN_WAIT:  adv = in_valid;
      S_OUT_WAIT: adv = out_ready;
      S_SCAN_FWD: begin
        case (prog_data)
          OP_LOL: begin
            if (depth_full) state_next = S_ERROR;
            else begin depth_next = depth + DEPTH_ONE; fwd = 1'b1; end
          end
          OP_LOR: begin
            if (depth == DEPTH_ONE) adv = 1'b1;
            else begin depth_next = depth - DEPTH_ONE; fwd = 1'b1; end
          end
          default: fwd = 1'b1;
        endcase
      end
      S_SCAN_BWD: begin
        case (prog_data)
          OP_LOR: begin
            if (depth_full) state_next = S_ERROR;
            else begin depth_next = depth + DEPTH_ONE; bwd = 1'b1; end
          end
          OP_LOL: begin
            if (depth == DEPTH_ONE) adv = 1'b1;
            else begin depth_next = depth - DEPTH_ONE; bwd = 1'b1; end
          end
          default: bwd = 1'b1;
        endcase
      end
      default: state_next = S_IDLE;
    endcase

    if (adv) begin
      if (pc_last) state_next = S_HALT;
      else begin pc_next = pc + PC_ONE; state_next = S_EXEC; end
    end
    if (fwd) begin
      if (pc_last) state_next = S_ERROR;
      else pc_next = pc + PC_ONE;
    end
    if (bwd) begin
      if (pc_first) state_next = S_ERROR;
      else pc_next = pc - PC_ONE;
    end
  end

  always_ff @(posedge working_clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      depth    <= '0;
      out_data <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      depth    <= depth_next;
      out_data <= out_data_next;
    end
  end

endmodule

// File: tb/tb_bf_exec_unit.sv
// Bench for bf_exec_unit: directed vector table, hand-written corner sequences, and random programs
// checked against a plain Brainfuck interpreter with a small tape model standing in for the tape.
module tb_bf_exec_unit;

  logic       working_clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] prog_addr;
  logic [3:0] prog_data;
  logic       tape_ready = 1'b1;
  logic [3:0] tape_symbol;
  logic [3:0] tape_new_symbol;
  logic       tape_set_symbol, tape_move, tape_move_dir, roll_back, tape_delete;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, out_valid;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy, halted, error;
`ifdef BF_EXEC_STEP_EN
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
`endif

  always #5 working_clock = ~working_clock;

  bf_exec_unit #(.PC_WIDTH(8), .DEPTH_WIDTH(6)) dut (
    .working_clock(working_clock), .reset(reset), .start(start),
`ifdef BF_EXEC_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .prog_addr(prog_addr), .prog_data(prog_data),
    .tape_ready(tape_ready), .tape_symbol(tape_symbol), .tape_new_symbol(tape_new_symbol),
    .tape_set_symbol(tape_set_symbol), .tape_move(tape_move), .tape_move_dir(tape_move_dir),
    .roll_back(roll_back), .tape_delete(tape_delete),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .halted(halted), .error(error)
  );

  // Program memory and a 16-cell wrapping tape owned by the bench.
  logic [3:0] prog_mem [256];
  logic [3:0] tape [16];
  logic [3:0] tinit [16];
  logic [3:0] tptr = '0;
  logic       tload = 1'b0;

  assign prog_data   = prog_mem[prog_addr];
  assign tape_symbol = tape[tptr];

  always @(posedge working_clock) begin
    if (tload) begin
      for (int i = 0; i < 16; i++) tape[i] <= tinit[i];
      tptr <= '0;
    end else begin
      if (tape_set_symbol) tape[tptr] <= tape_new_symbol;
      if (tape_delete) tape[tptr] <= '0;
      if (tape_move) tptr <= tape_move_dir ? tptr + 4'd1 : tptr - 4'd1;
      if (roll_back) tptr <= '0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_tape(input logic [3:0] a [16]);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = a[i];
    return r;
  endfunction

  // Run bookkeeping shared by the runner and the checkers.
  logic [3:0] ins [$];
  logic [3:0] outs [$];
  int moves, viol, back_steps, cyc, in_idx;
  bit timed_out;

  task automatic do_start();
    start = 1'b1;
    @(posedge working_clock); #1;
    start = 1'b0;
  endtask

  task automatic load_tape();
    tload = 1'b1;
    @(posedge working_clock); #1;
    tload = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog_mem[i] = 4'd0;
  endtask

  task automatic run_prog(input bit rnd, input int budget);
    logic [7:0] prev_addr;
    int nstrobe;
    outs.delete();
    moves = 0; viol = 0; back_steps = 0; cyc = 0; in_idx = 0; timed_out = 1'b0;
    do_start();
    prev_addr = prog_addr;
    while (busy) begin
      if (cyc >= budget) begin timed_out = 1'b1; break; end
      tape_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid   = (in_idx < ins.size()) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      in_data    = in_valid ? ins[in_idx] : 4'd0;
      out_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      nstrobe = int'(tape_set_symbol) + int'(tape_move) + int'(roll_back) + int'(tape_delete);
      if (nstrobe > 1) viol++;
      if (!tape_ready && (tape_move || roll_back || tape_delete || (tape_set_symbol && !in_ready))) viol++;
      if (tape_move) moves++;
      if (in_ready && in_valid) in_idx++;
      if (out_valid && out_ready) outs.push_back(out_data);
      @(posedge working_clock); #1;
      cyc++;
      if (prog_addr < prev_addr) back_steps++;
      prev_addr = prog_addr;
    end
    tape_ready = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    if (tape_set_symbol || tape_move || roll_back || tape_delete) viol++;
  endtask

  // Reference interpreter: runs the program directly on an array tape with explicit bracket matching.
  localparam int ST_HALT = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_LONG = 3;
  int         m_status, m_cost, m_pc;
  logic [3:0] m_tape [16];
  logic [3:0] m_ptr;
  logic [3:0] m_outs [$];

  task automatic model_run();
    int pc, d, a, nin;
    bit found, done, adv;
    logic [3:0] t [16];
    logic [3:0] ptr;
    logic [3:0] op;
    t = tinit; ptr = '0; pc = 0; nin = 0; done = 0;
    m_cost = 0; m_outs.delete(); m_status = ST_LONG;
    while (!done && m_cost < 400) begin
      m_cost++;
      op = prog_mem[pc];
      adv = 1;
      case (op)
        4'd0: begin m_status = ST_HALT; done = 1; adv = 0; end
        4'd1: t[ptr] = t[ptr] + 4'd1;
        4'd2: t[ptr] = t[ptr] - 4'd1;
        4'd3: ptr = ptr - 4'd1;
        4'd4: ptr = ptr + 4'd1;
        4'd5: begin
          if (nin >= ins.size()) begin m_status = ST_LONG; done = 1; adv = 0; end
          else begin t[ptr] = ins[nin]; nin++; m_cost++; end
        end
        4'd6: begin m_outs.push_back(t[ptr]); m_cost++; end
        4'd7: if (t[ptr] == 4'd0) begin
          d = 1; found = 0; a = pc;
          while (!found && !done) begin
            if (a == 255) begin m_status = ST_ERR; done = 1; end
            else begin
              a++; m_cost++;
              if (prog_mem[a] == 4'd7) begin
                if (d == 63) begin m_status = ST_ERR; done = 1; end else d++;
              end else if (prog_mem[a] == 4'd8) begin
                d--; if (d == 0) found = 1;
              end
            end
          end
          if (done) adv = 0;
          pc = a;
        end
        4'd8: if (t[ptr] != 4'd0) begin
          d = 1; found = 0; a = pc;
          while (!found && !done) begin
            if (a == 0) begin m_status = ST_ERR; done = 1; end
            else begin
              a--; m_cost++;
              if (prog_mem[a] == 4'd8) begin
                if (d == 63) begin m_status = ST_ERR; done = 1; end else d++;
              end else if (prog_mem[a] == 4'd7) begin
                d--; if (d == 0) found = 1;
              end
            end
          end
          if (done) adv = 0;
          pc = a;
        end
        4'd9:  ptr = '0;
        4'd10: t[ptr] = 4'd0;
        default: ;
      endcase
      if (adv) begin
        if (pc == 255) begin m_status = ST_HALT; done = 1; end
        else pc++;
      end
    end
    m_pc = pc; m_tape = t; m_ptr = ptr;
  endtask

  typedef struct {
    logic [31:0] prog;     // first opcode in the top nibble
    logic [3:0]  in_val;
    bit          has_in;
    int          exp_status;
    int          exp_nouts;
    logic [3:0]  exp_out;
    logic [3:0]  exp_cell0;
    int          exp_moves;
    int          exp_back;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [11];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    string nm;
    int lim;

    vecs[0]  = '{32'h1116_0000, 4'd0, 0, ST_HALT, 1, 4'd3,  4'd3,  0, 0, 6};
    vecs[1]  = '{32'h2600_0000, 4'd0, 0, ST_HALT, 1, 4'd15, 4'd15, 0, 0, 4};
    vecs[2]  = '{32'h1172_8000, 4'd0, 0, ST_HALT, 0, 4'd0,  4'd0,  0, 2, 10};
    vecs[3]  = '{32'h7481_6000, 4'd0, 0, ST_HALT, 1, 4'd1,  4'd1,  0, 0, 7};
    vecs[4]  = '{32'h1800_0000, 4'd0, 0, ST_ERR,  0, 4'd0,  4'd1,  0, 1, 3};
    vecs[5]  = '{32'h5600_0000, 4'd9, 1, ST_HALT, 1, 4'd9,  4'd9,  0, 0, 5};
    vecs[6]  = '{32'h11A6_0000, 4'd0, 0, ST_HALT, 1, 4'd0,  4'd0,  0, 0, 6};
    vecs[7]  = '{32'h1496_0000, 4'd0, 0, ST_HALT, 1, 4'd1,  4'd1,  1, 0, 6};
    vecs[8]  = '{32'h1436_0000, 4'd0, 0, ST_HALT, 1, 4'd1,  4'd1,  2, 0, 6};
    vecs[9]  = '{32'h1BCF_6000, 4'd0, 0, ST_HALT, 1, 4'd1,  4'd1,  0, 0, 7};
    vecs[10] = '{32'h7000_0000, 4'd0, 0, ST_ERR,  0, 4'd0,  4'd0,  0, 0, 256};

    for (int i = 0; i < 16; i++) tinit[i] = 4'd0;
    clear_prog();

    // Reset state
    repeat (2) @(posedge working_clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_pc", prog_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_strobes", {tape_set_symbol, tape_move, roll_back, tape_delete}, 0);
    reset = 1'b0;
    @(posedge working_clock); #1;

    // Directed vector table
    for (int k = 0; k < 11; k++) begin
      v = vecs[k];
      clear_prog();
      for (int i = 0; i < 8; i++) prog_mem[i] = v.prog[31-4*i -: 4];
      for (int i = 0; i < 16; i++) tinit[i] = 4'd0;
      load_tape();
      ins.delete();
      if (v.has_in) ins.push_back(v.in_val);
      run_prog(1'b0, 600);
      nm = $sformatf("vec%0d", k);
      chk({nm, "_timeout"}, timed_out, 0);
      chk({nm, "_status"}, {error, halted}, v.exp_status);
      chk({nm, "_nouts"}, outs.size(), v.exp_nouts);
      if (v.exp_nouts > 0 && outs.size() > 0) chk({nm, "_out"}, outs[outs.size()-1], v.exp_out);
      chk({nm, "_cell0"}, tape[0], v.exp_cell0);
      chk({nm, "_moves"}, moves, v.exp_moves);
      chk({nm, "_back_steps"}, back_steps, v.exp_back);
      chk({nm, "_cycles"}, cyc, v.exp_cycles);
      chk({nm, "_strobe_rules"}, viol, 0);
    end

    // out_valid appears exactly five edges after start and holds out_data while out_ready is low
    clear_prog();
    prog_mem[0] = 4'd1; prog_mem[1] = 4'd1; prog_mem[2] = 4'd1; prog_mem[3] = 4'd6;
    for (int i = 0; i < 16; i++) tinit[i] = 4'd0;
    load_tape();
    out_ready = 1'b0;
    do_start();
    repeat (3) @(posedge working_clock);
    #1;
    chk("oup_not_yet", out_valid, 0);
    @(posedge working_clock); #1;
    chk("oup_valid_c5", out_valid, 1);
    chk("oup_data_c5", out_data, 3);
    repeat (2) @(posedge working_clock);
    #1;
    chk("oup_hold_valid", out_valid, 1);
    chk("oup_hold_data", out_data, 3);
    out_ready = 1'b1;
    @(posedge working_clock); #1;
    out_ready = 1'b0;
    @(posedge working_clock); #1;
    chk("oup_then_halt", halted, 1);

    // Input stall: no write while in_valid is low, start ignored while busy, async reset in OUT_WAIT
    clear_prog();
    prog_mem[0] = 4'd5; prog_mem[1] = 4'd6;
    for (int i = 0; i < 16; i++) tinit[i] = 4'd7;
    load_tape();
    in_valid = 1'b0;
    do_start();
    @(posedge working_clock); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("inwait_ready%0d", i), in_ready, 1);
      chk($sformatf("inwait_noset%0d", i), tape_set_symbol, 0);
      if (i == 1) start = 1'b1;
      @(posedge working_clock); #1;
      start = 1'b0;
    end
    chk("inwait_start_ignored", {in_ready, prog_addr}, {1'b1, 8'd0});
    in_valid = 1'b1; in_data = 4'd9;
    #1;
    chk("inwait_accept_set", {tape_set_symbol, tape_new_symbol}, {1'b1, 4'd9});
    @(posedge working_clock); #1;
    in_valid = 1'b0;
    chk("inwait_cell", tape[0], 9);
    @(posedge working_clock); #1;
    chk("inwait_out_valid", out_valid, 1);
    chk("inwait_out_data", out_data, 9);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_idle", {busy, halted, error, prog_addr}, 0);
    @(posedge working_clock); #1;
    reset = 1'b0;
    @(posedge working_clock); #1;

    // Error recovery: start from ERROR restarts at pc 0
    clear_prog();
    prog_mem[0] = 4'd1; prog_mem[1] = 4'd8;
    for (int i = 0; i < 16; i++) tinit[i] = 4'd0;
    load_tape();
    ins.delete();
    run_prog(1'b0, 50);
    chk("err_flag", error, 1);
    do_start();
    chk("err_restart", {busy, error, prog_addr}, {1'b1, 1'b0, 8'd0});
    repeat (4) @(posedge working_clock);
    #1;

    // Running off the last address halts without error
    for (int i = 0; i < 256; i++) prog_mem[i] = 4'd11;
    run_prog(1'b0, 400);
    chk("wrap_status", {error, halted}, ST_HALT);
    chk("wrap_pc", prog_addr, 255);
    chk("wrap_cycles", cyc, 256);

    // Random programs against the interpreter
    for (int p = 0; p < 30; p++) begin
      m_status = ST_LONG;
      for (int tries = 0; tries < 50 && m_status == ST_LONG; tries++) begin
        int len, r;
        clear_prog();
        len = $urandom_range(3, 14);
        for (int i = 0; i < len; i++) begin
          r = $urandom_range(1, 19);
          prog_mem[i] = (r <= 15) ? 4'(r) : (r == 16) ? 4'd1 : (r == 17) ? 4'd2 : (r == 18) ? 4'd7 : 4'd8;
        end
        for (int i = 0; i < 16; i++) tinit[i] = 4'($urandom_range(0, 15));
        ins.delete();
        for (int i = 0; i < 6; i++) ins.push_back(4'($urandom_range(0, 15)));
        model_run();
      end
      if (m_status == ST_LONG) continue;
      load_tape();
      lim = 5 * m_cost + 300;
      run_prog(1'b1, lim);
      nm = $sformatf("rnd%0d", p);
      chk({nm, "_timeout"}, timed_out, 0);
      chk({nm, "_status"}, {error, halted}, m_status);
      chk({nm, "_pc"}, prog_addr, m_pc);
      chk({nm, "_nouts"}, outs.size(), m_outs.size());
      for (int i = 0; i < outs.size() && i < m_outs.size(); i++)
        chk($sformatf("%s_out%0d", nm, i), outs[i], m_outs[i]);
      chk({nm, "_tape"}, pack_tape(tape), pack_tape(m_tape));
      chk({nm, "_ptr"}, tptr, m_ptr);
      chk({nm, "_strobe_rules"}, viol, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
